bp_fe_bht_gshare: RTL and testbench
===================================

// Module: bp_fe_bht_gshare
// PURPOSE
//  Parametrised gshare branch history table for the FE predictor; next generation of the 2-bit BHT.
//  Adds the following over that block:
//  - configurable counter width and global-history length
//  - registered one-cycle read
//  - speculative global history with checkpoint restore on mispredict
//  - sequential table-clear FSM after reset
//  Sits beside the BTB in the FE pc-gen stage; resolution updates arrive from the BE redirect path.
// PARAMETERS
//  bht_idx_width_p  9  table index width; els = 2**bht_idx_width_p entries
//  ghist_width_p    4  global history bits, XORed into idx[ghist_width_p-1:0]; 1 <= ghist <= idx width
//  ctr_width_p      2  saturating counter width (>=2); MSB = taken prediction
// PORTS
//  clk_i         in   1     clock
//  reset_i       in   1     reset, synchronous, active-high
//  init_done_o   out  1     table clear finished; reads/writes accepted only when 1
//  r_v_i         in   1     prediction lookup request
//  idx_r_i       in   idx   lookup index (pc bits)
//  predict_v_o   out  1     lookup result valid, one cycle after accepted r_v_i
//  predict_o     out  1     predicted direction (counter MSB)
//  ghist_o       out  ghist history snapshot used for this lookup; FE carries it to resolution
//  w_v_i         in   1     resolution update
//  idx_w_i       in   idx   resolved branch index (pc bits)
//  ghist_w_i     in   ghist snapshot returned with the branch
//  taken_i       in   1     actual direction
//  mispredict_i  in   1     branch was mispredicted; qualifies w_v_i
// BEHAVIOUR
//  - Index = {idx[hi:ghist], idx[ghist-1:0] ^ hist}.
//    Reads use the live speculative history; writes use ghist_w_i.
//  - FSM e_reset -> e_clear -> e_run.
//    - reset_i high: state e_reset, clear ptr 0, hist 0, all outputs 0.
//    - e_clear: writes INIT = 2**(ctr-1)-1 (weak not-taken, 2'b01) to entry ptr, one per cycle.
//      Leaves after entry els-1, so exactly els cycles after reset_i falls.
//    - e_run: init_done_o=1.
//    - r_v_i/w_v_i outside e_run are dropped, with no state change.
//    - Reset mid-clear restarts the clear from entry 0.
//  - Read: r_v_i in e_run at cycle t gives predict_v_o=1, predict_o and ghist_o at t+1.
//    Outputs are registered; predict_v_o is 0 otherwise; predict_o/ghist_o hold their last value.
//  - Speculative history: in a cycle with predict_v_o=1, hist <= {hist[ghist-2:0], predict_o}.
//  - Update (w_v_i): taken_i increments, else decrements, saturating at 2**ctr-1 and 0.
//    Full ctr_width_p arithmetic; no wrap.
//  - Mispredict (w_v_i & mispredict_i): hist <= {ghist_w_i[ghist-2:0], taken_i} at the next edge.
//    Overrides any speculative shift in the same cycle.
//    w_v_i without mispredict_i leaves hist untouched.
//  - Same-cycle read and write to the same table entry: the write always commits.
//    Read value depends on CONFIGURATION.
//  - One read and one write per cycle; no backpressure; no ready outputs.
// CONFIGURATION
//  BP_FE_BHT_BYPASS_EN
//  - Defined: a same-entry read/write collision returns the post-update counter MSB.
//  - Undefined: the read returns the pre-update MSB (array read-before-write). No other difference.
// TESTING
//  1. Release reset at t0 -> init_done_o=0 for 512 cycles, 1 at t0+512. Any read then gives predict_o=0.
//  2. Reset pulse during clear at ptr=100 -> init_done_o stays 0; rises 512 cycles after the second release.
//  3. Entry 5, ghist_w_i=0, three taken updates -> counter 01->10->11->11.
//     Then three not-taken -> 10->01->00; a fourth stays 00. Reads in between track the MSB.
//  4. Two reads with hist=0 predicting 0 then 1 -> ghist_o=0000 then 0000 (pre-shift); hist becomes 0001.
//     Then w_v_i, mispredict_i, ghist_w_i=1010, taken_i=1 -> next read ghist_o=0101.
//  5. Same-cycle predict_v_o=1 shift and mispredict restore -> restore value wins; no shift applied.
//  6. Entry counter 01, same-cycle read and taken write to it -> predict_o=1 with BYPASS_EN, 0 without;
//     counter=10 in both builds.

Source files
------------

// File: rtl/bp_fe_bht_gshare.sv
// bp_fe_bht_gshare: gshare branch history table for the FE predictor.
// Provides a registered one-cycle lookup and saturating-counter updates,
// and keeps a speculative global history with mispredict restore. After
// reset, a sequential FSM clears the table before it accepts lookups.
// Optional macro BP_FE_BHT_BYPASS_EN: when it is defined, a lookup that hits
// the entry being written in the same cycle returns the updated counter MSB.
module bp_fe_bht_gshare #(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 4,
  parameter int ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic [ghist_width_p-1:0]   ghist_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic [ghist_width_p-1:0]   ghist_w_i,
  input  logic                       taken_i,
  input  logic                       mispredict_i
);

  localparam int els_lp = 1 << bht_idx_width_p;
  // Weak not-taken: MSB clear, all lower bits set.
  localparam logic [ctr_width_p-1:0] ctr_init_lp = {1'b0, {(ctr_width_p-1){1'b1}}};
  localparam logic [ctr_width_p-1:0] ctr_max_lp  = '1;

  typedef enum logic [1:0] {e_reset, e_clear, e_run} state_e;

  state_e                     state, state_n;
  logic [bht_idx_width_p-1:0] ptr, ptr_n;
  logic                       clearing;
  logic                       run;

  logic [ghist_width_p-1:0]   hist;
  logic [ghist_width_p-1:0]   hist_shift;
  logic [ghist_width_p-1:0]   hist_restore;

  logic [ctr_width_p-1:0]     mem [els_lp];

  logic [bht_idx_width_p-1:0] r_idx, w_idx;
  logic                       r_en, w_en;
  logic [ctr_width_p-1:0]     w_cur, w_upd, rd_ctr;

  logic                       mem_we;
  logic [bht_idx_width_p-1:0] mem_waddr;
  logic [ctr_width_p-1:0]     mem_wdata;

  assign run         = (state == e_run);
  assign init_done_o = run;
  assign r_en        = r_v_i & run;
  assign w_en        = w_v_i & run;

  // The history only touches the low index bits, so it is zero-extended before the XOR.
  assign r_idx = idx_r_i ^ bht_idx_width_p'(hist);
  assign w_idx = idx_w_i ^ bht_idx_width_p'(ghist_w_i);

  // Next history values; a one-bit history simply becomes the new outcome.
  if (ghist_width_p == 1) begin : g_hist1
    assign hist_shift   = predict_o;
    assign hist_restore = taken_i;
  end else begin : g_histn
    assign hist_shift   = {hist[ghist_width_p-2:0], predict_o};
    assign hist_restore = {ghist_w_i[ghist_width_p-2:0], taken_i};
  end

  // FSM state and clear pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= e_reset;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Clear sequencing: e_reset already clears entry 0, so the whole sweep takes els cycles.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    clearing = 1'b0;
    case (state)
      e_reset: begin
        clearing = 1'b1;
        ptr_n    = ptr + bht_idx_width_p'(1);
        state_n  = e_clear;
      end
      e_clear: begin
        clearing = 1'b1;
        ptr_n    = ptr + bht_idx_width_p'(1);
        if (ptr == '1) state_n = e_run;
      end
      default: ;
    endcase
  end

  // Saturating counter update for the resolved entry.
  always_comb begin
    w_cur = mem[w_idx];
    w_upd = w_cur;
    if (taken_i) begin
      if (w_cur != ctr_max_lp) w_upd = w_cur + ctr_width_p'(1);
    end else begin
      if (w_cur != '0) w_upd = w_cur - ctr_width_p'(1);
    end
  end

  // Lookup value, with optional forwarding of a same-entry update.
  always_comb begin
    rd_ctr = mem[r_idx];
`ifdef BP_FE_BHT_BYPASS_EN
    if (w_en && (w_idx == r_idx)) rd_ctr = w_upd;
`endif
  end

  // Single write port shared by the clear sweep and resolution updates.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_idx;
    mem_wdata = w_upd;
    if (clearing && !reset_i) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = ctr_init_lp;
    end else if (w_en) begin
      mem_we = 1'b1;
    end
  end

  // Table array; the read above sees the old contents (read-before-write).
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered lookup outputs; direction and snapshot hold between lookups.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      predict_v_o <= 1'b0;
      predict_o   <= 1'b0;
      ghist_o     <= '0;
    end else begin
      predict_v_o <= r_en;
      if (r_en) begin
        predict_o <= rd_ctr[ctr_width_p-1];
        ghist_o   <= hist;
      end
    end
  end

  // Speculative history: a mispredict restore takes priority over the predicted-direction shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist <= '0;
    end else if (w_en && mispredict_i) begin
      hist <= hist_restore;
    end else if (predict_v_o) begin
      hist <= hist_shift;
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Self-checking bench for bp_fe_bht_gshare: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the table.
module tb_bp_fe_bht_gshare;

  localparam int IW   = 9;
  localparam int GW   = 4;
  localparam int CW   = 2;
  localparam int ELS  = 1 << IW;
  localparam int CMAX = (1 << CW) - 1;
  localparam int INIT = (1 << (CW - 1)) - 1;
  localparam int HMOD = 1 << GW;
`ifdef BP_FE_BHT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, reset_i, init_done_o;
  logic          r_v_i, predict_v_o, predict_o;
  logic [IW-1:0] idx_r_i, idx_w_i;
  logic [GW-1:0] ghist_o, ghist_w_i;
  logic          w_v_i, taken_i, mispredict_i;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state.
  int cnt [ELS];
  int m_hist, m_clr;
  bit m_done;
  bit e_pv, e_p;
  int e_gh;

  bp_fe_bht_gshare #(.bht_idx_width_p(IW), .ghist_width_p(GW), .ctr_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .r_v_i(r_v_i), .idx_r_i(idx_r_i),
    .predict_v_o(predict_v_o), .predict_o(predict_o), .ghist_o(ghist_o),
    .w_v_i(w_v_i), .idx_w_i(idx_w_i), .ghist_w_i(ghist_w_i),
    .taken_i(taken_i), .mispredict_i(mispredict_i)
  );

  always #5 clk = ~clk;

  task automatic idle();
    r_v_i = 0; idx_r_i = '0; w_v_i = 0; idx_w_i = '0;
    ghist_w_i = '0; taken_i = 0; mispredict_i = 0;
  endtask

  // Advance model and DUT by one clock with the currently driven inputs.
  task automatic tick();
    int ri, wi, cur, upd, val, nh;
    if (reset_i) begin
      m_done = 0; m_clr = 0; m_hist = 0; e_pv = 0; e_p = 0; e_gh = 0;
    end else if (!m_done) begin
      e_pv = 0;
      m_clr++;
      if (m_clr == ELS) begin
        m_done = 1;
        foreach (cnt[i]) cnt[i] = INIT;
      end
    end else begin
      ri  = int'(idx_r_i) ^ m_hist;
      wi  = int'(idx_w_i) ^ int'(ghist_w_i);
      cur = cnt[wi];
      upd = taken_i ? ((cur == CMAX) ? CMAX : cur + 1) : ((cur == 0) ? 0 : cur - 1);
      nh  = m_hist;
      if (w_v_i && mispredict_i) nh = (int'(ghist_w_i) * 2 + int'(taken_i)) % HMOD;
      else if (e_pv)             nh = (m_hist * 2 + int'(e_p)) % HMOD;
      e_pv = r_v_i;
      if (r_v_i) begin
        val = cnt[ri];
        if (BYP && w_v_i && wi == ri) val = upd;
        e_p  = (val >= (1 << (CW - 1)));
        e_gh = m_hist;
      end
      if (w_v_i) cnt[wi] = upd;
      m_hist = nh;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic init_table();
    idle();
    reset_i = 1;
    tick(); tick();
    reset_i = 0;
    repeat (ELS) tick();
  endtask

  task automatic test_reset();
    idle();
    reset_i = 1;
    tick(); tick();
    n_chk++;
    if ({init_done_o, predict_v_o, predict_o, ghist_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {init_done_o, predict_v_o, predict_o, ghist_o});
    end
    reset_i = 0;
    r_v_i = 1;
    for (int k = 1; k <= ELS; k++) begin
      idx_r_i = IW'($urandom_range(0, ELS - 1));
      tick();
      n_chk++;
      if (init_done_o !== (k >= ELS)) begin
        n_fail++;
        $display("FAIL init_done cycle %0d: got %b required %b", k, init_done_o, (k >= ELS));
      end
      n_chk++;
      if (predict_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL read_during_clear cycle %0d: got predict_v %b required 0", k, predict_v_o);
      end
    end
    for (int k = 0; k < 4; k++) begin
      idx_r_i = IW'($urandom_range(0, ELS - 1));
      tick();
      n_chk++;
      if ({predict_v_o, predict_o} !== 2'b10) begin
        n_fail++;
        $display("FAIL read_after_clear: got v/p %b%b required 10", predict_v_o, predict_o);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    init_table();
    reset_i = 1; tick();
    reset_i = 0;
    repeat (100) tick();
    reset_i = 1; tick();
    reset_i = 0;
    repeat (ELS - 1) tick();
    n_chk++;
    if (init_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_early: got init_done %b required 0", init_done_o);
    end
    tick();
    n_chk++;
    if (init_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_clear_done: got init_done %b required 1", init_done_o);
    end
  endtask

  task automatic test_counter();
    bit tk  [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit exp [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    init_table();
    for (int s = 0; s < 9; s++) begin
      idle();
      w_v_i = 1; idx_w_i = IW'(5); ghist_w_i = '0; taken_i = tk[s];
      tick();
      idle();
      r_v_i = 1; idx_r_i = IW'(5 ^ m_hist);
      tick();
      idle();
      n_chk++;
      if ({predict_v_o, predict_o} !== {1'b1, exp[s]}) begin
        n_fail++;
        $display("FAIL counter step %0d: got v/p %b%b required 1%b", s, predict_v_o, predict_o, exp[s]);
      end
    end
    tick();
  endtask

  task automatic test_ghist();
    init_table();
    w_v_i = 1; idx_w_i = IW'(9); taken_i = 1;
    tick();
    idle();
    r_v_i = 1; idx_r_i = IW'(3);
    tick();
    n_chk++;
    if ({predict_o, ghist_o} !== {1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL ghist_read0: got p %b gh %b required 0 0000", predict_o, ghist_o);
    end
    idx_r_i = IW'(9);
    tick();
    idle();
    n_chk++;
    if ({predict_o, ghist_o} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL ghist_read1: got p %b gh %b required 1 0000", predict_o, ghist_o);
    end
    tick();
    r_v_i = 1; idx_r_i = IW'(0);
    tick();
    idle();
    n_chk++;
    if (ghist_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL ghist_shifted: got %b required 0001", ghist_o);
    end
    tick();
    w_v_i = 1; mispredict_i = 1; ghist_w_i = 4'b1010; taken_i = 1; idx_w_i = IW'(20);
    tick();
    idle();
    r_v_i = 1;
    tick();
    idle();
    n_chk++;
    if (ghist_o !== 4'b0101) begin
      n_fail++;
      $display("FAIL ghist_restore: got %b required 0101", ghist_o);
    end
  endtask

  task automatic test_restore_wins();
    // predict_v_o is high from the read in test_ghist during this mispredict cycle.
    w_v_i = 1; mispredict_i = 1; ghist_w_i = 4'b0011; taken_i = 0; idx_w_i = IW'(40);
    tick();
    idle();
    r_v_i = 1;
    tick();
    idle();
    n_chk++;
    if (ghist_o !== 4'b0110) begin
      n_fail++;
      $display("FAIL restore_over_shift: got %b required 0110", ghist_o);
    end
    tick();
  endtask

  task automatic test_collision();
    init_table();
    r_v_i = 1; idx_r_i = IW'(7);
    w_v_i = 1; idx_w_i = IW'(7); ghist_w_i = '0; taken_i = 1;
    tick();
    idle();
    n_chk++;
    if ({predict_v_o, predict_o} !== {1'b1, BYP}) begin
      n_fail++;
      $display("FAIL collision_read: got v/p %b%b required 1%b", predict_v_o, predict_o, BYP);
    end
    tick();
    r_v_i = 1; idx_r_i = IW'(7 ^ m_hist);
    tick();
    idle();
    n_chk++;
    if (predict_o !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_commit: got p %b required 1", predict_o);
    end
    tick();
  endtask

  task automatic test_random();
    idle();
    reset_i = 1; tick();
    reset_i = 0;
    for (int c = 0; c < 2000; c++) begin
      reset_i      = ($urandom_range(0, 999) == 0);
      r_v_i        = $urandom_range(0, 1);
      idx_r_i      = IW'($urandom_range(0, 15));
      w_v_i        = $urandom_range(0, 1);
      idx_w_i      = IW'($urandom_range(0, 15));
      ghist_w_i    = GW'($urandom_range(0, HMOD - 1));
      taken_i      = $urandom_range(0, 1);
      mispredict_i = ($urandom_range(0, 3) == 0);
      tick();
      n_chk++;
      if ({init_done_o, predict_v_o} !== {m_done, e_pv}) begin
        n_fail++;
        $display("FAIL rand_valid cycle %0d: got done/v %b%b required %b%b", c, init_done_o, predict_v_o, m_done, e_pv);
      end
      if (e_pv) begin
        n_chk++;
        if ({predict_o, ghist_o} !== {e_p, GW'(e_gh)}) begin
          n_fail++;
          $display("FAIL rand_predict cycle %0d: got p %b gh %b required p %b gh %b", c, predict_o, ghist_o, e_p, GW'(e_gh));
        end
      end
    end
    reset_i = 0;
    idle();
  endtask

  initial begin
    clk = 0;
    reset_i = 1;
    idle();
    test_reset();
    test_reset_mid_clear();
    test_counter();
    test_ghist();
    test_restore_wins();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
